// File: rtl/sensor_hub_pkg.sv
// Shared constants and helpers for the sensor data hub.
// Default geometry models accel, gyro and magnetometer channels.
package sensor_hub_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_OVR_W  = 8;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_chan_fifo.sv
// Per-channel sample FIFO.
// Pointers carry an extra wrap bit so full and empty are distinct.
module sensor_chan_fifo
  import sensor_hub_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data  = r_mem[r_rd[AW-1:0]];

  // Pointer update; contents are discarded by emptying on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + (AW+1)'(1);
      if (i_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // Sample storage write.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sensor_data_hub.sv
// Multi-channel sensor hub: per-channel FIFOs, round-robin
// arbiter, one output register and saturating overrun counters.
module sensor_data_hub
  import sensor_hub_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int OVR_W  = DEF_OVR_W,
  localparam int CW     = ch_idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_CH-1:0]        sample_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] sample_data_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [CW-1:0]            out_ch_o,
  output logic [NUM_CH*OVR_W-1:0]  ovr_count_o,
  input  logic                     ovr_clear_i
);

  logic [NUM_CH-1:0]             w_empty;
  logic [NUM_CH-1:0]             w_full;
  logic [NUM_CH-1:0]             w_push;
  logic [NUM_CH-1:0]             w_pop;
  logic [NUM_CH-1:0]             w_ovr;
  logic [NUM_CH-1:0][DATA_W-1:0] w_head;
  logic [CW-1:0]                 w_grant;
  logic                          w_found;
  logic                          w_load;
  int                            w_idx;

  logic                          r_valid;
  logic [DATA_W-1:0]             r_data;
  logic [CW-1:0]                 r_ch;
  logic [CW-1:0]                 r_last;

  assign w_load = (!r_valid || out_ready_i) && !(&w_empty);

  // Round-robin search starting one past the last grant.
  always_comb begin
    w_grant = r_last;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = (int'(r_last) + i) % NUM_CH;
      if (!w_found && !w_empty[w_idx]) begin
        w_grant = CW'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_pop[k]  = w_load && (w_grant == CW'(k));
    assign w_push[k] = sample_valid_i[k] &&
                       (!w_full[k] || w_pop[k]);
    assign w_ovr[k]  = sample_valid_i[k] &&
                       w_full[k] && !w_pop[k];
    assign ch_ready_o[k] = !w_empty[k] ||
                           (r_valid && r_ch == CW'(k));

    sensor_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_push  (w_push[k]),
      .i_data  (sample_data_i[k*DATA_W +: DATA_W]),
      .i_pop   (w_pop[k]),
      .o_data  (w_head[k]),
      .o_empty (w_empty[k]),
      .o_full  (w_full[k])
    );

    logic [OVR_W-1:0] r_ovr;

    // Saturating drop counter; clear wins but keeps a fresh drop.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_ovr <= '0;
      end else if (ovr_clear_i) begin
        r_ovr <= w_ovr[k] ? OVR_W'(1) : '0;
      end else if (w_ovr[k] && !(&r_ovr)) begin
        r_ovr <= r_ovr + OVR_W'(1);
      end
    end

    assign ovr_count_o[k*OVR_W +: OVR_W] = r_ovr;
  end

  // Output register: load on free slot, clear on empty transfer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_last  <= CW'(NUM_CH-1);
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_head[w_grant];
      r_ch    <= w_grant;
      r_last  <= w_grant;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_ch_o    = r_ch;

endmodule

// File: doc/sensor_data_hub.md
SENSOR_DATA_HUB -- requirements
Module: sensor_data_hub

Interface
REQ-001 Parameter NUM_CH, default 3, number of sensor channels (1..8); the defaults model accelerometer, gyroscope and magnetometer.
REQ-002 Parameter DATA_W, default 16, sample width in bits.
REQ-003 Parameter DEPTH, default 4, per-channel FIFO depth (power of 2, at least 2).
REQ-004 Parameter OVR_W, default 8, per-channel overrun counter width.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 n_rst  in  1  reset, asynchronous, active-low.
REQ-007 sample_valid_i  in  NUM_CH  one-cycle strobe per channel; new sample present.
REQ-008 sample_data_i  in  NUM_CH*DATA_W  channel k sample at [k*DATA_W +: DATA_W].
REQ-009 ch_ready_o  out  NUM_CH  channel k has at least one undelivered sample.
REQ-010 out_valid_o  out  1  output register holds a sample.
REQ-011 out_ready_i  in  1  consumer accepts the sample.
REQ-012 out_data_o  out  DATA_W  delivered sample.
REQ-013 out_ch_o  out  max(1,$clog2(NUM_CH))  source channel of out_data_o.
REQ-014 ovr_count_o  out  NUM_CH*OVR_W  saturating dropped-sample count for channel k at [k*OVR_W +: OVR_W].
REQ-015 ovr_clear_i  in  1  synchronous clear of all overrun counters.

Function
REQ-016 Strobe on channel k with FIFO k not full: the sample is written at that edge; ch_ready_o[k] is 1 from the next cycle.
REQ-017 Strobe on a full FIFO with no pop of that FIFO in the same cycle: the new sample is dropped, stored contents are unchanged, and ovr_count for channel k increments, saturating at 2^OVR_W-1.
REQ-018 Strobe and pop of a full FIFO in the same cycle: both take effect, with no overrun.
REQ-019 No bypass path: a sample always passes through its FIFO, so minimum latency from strobe to out_valid_o is 2 cycles.
REQ-020 Load condition: the output register loads when (!out_valid_o or out_ready_i) and any FIFO is non-empty.
REQ-021 On a load, the arbiter pops the head of the first non-empty channel in round-robin order, starting at last_grant+1 mod NUM_CH, then updates last_grant.
REQ-022 While out_valid_o=1 and out_ready_i=0, out_data_o and out_ch_o are held stable.
REQ-023 A transfer (out_valid_o and out_ready_i) with all FIFOs empty clears out_valid_o at the next edge.
REQ-024 ch_ready_o[k] = (FIFO k non-empty) OR (out_valid_o and out_ch_o==k).
REQ-025 ovr_clear_i sets all counters to 0; a coincident overrun on channel k sets that counter to 1.
REQ-026 FIFO pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit or an occupancy count.
REQ-027 out_ready_i asserted while out_valid_o=0 has no effect.

Reset
REQ-028 While n_rst=0: all FIFOs are emptied, ch_ready_o=0, out_valid_o=0, out_data_o=0, out_ch_o=0, ovr_count_o=0, last_grant=NUM_CH-1 (channel 0 wins first).
REQ-029 Assertion of reset mid-operation discards all buffered and in-flight samples, with no partial delivery after release.
REQ-030 Strobes in the first cycle after reset release are captured normally.

Structure
REQ-031 Package sensor_hub_pkg holds the default parameter constants and the channel-index width function.
REQ-032 The per-channel buffer is sub-module sensor_chan_fifo (DATA_W, DEPTH), instantiated NUM_CH times by generate.
REQ-033 The arbiter, output register and overrun counters reside in sensor_data_hub.

Verification
REQ-034 Single sample: ch1 strobe with 0x1234 at cycle 0, out_ready_i=1 -> out_valid_o=1 at cycle 2 with data 0x1234 and ch 1; ch_ready_o[1]=0 at cycle 3.
REQ-035 Round robin: ch0, ch1 and ch2 strobed together (0xA0, 0xB1, 0xC2), out_ready_i=1 -> delivered in order ch0, ch1, ch2 on consecutive cycles.
REQ-036 Overrun: 6 strobes on ch2 with out_ready_i=0 (DEPTH=4) -> ovr_count ch2 = 1 (output register absorbs one sample, FIFO holds 4, one dropped); later drain yields the first 5 samples in order.
REQ-037 Backpressure: out_ready_i=0 for 10 cycles with out_valid_o=1 -> out_data_o and out_ch_o are unchanged; pulsing out_ready_i delivers the next sample one cycle later.
REQ-038 Saturation/clear: OVR_W=2, 5 overruns -> count=3; ovr_clear_i with a coincident overrun -> count=1.
REQ-039 Reset mid-run: n_rst low with 3 samples buffered -> all outputs 0 immediately; no stale sample appears after release.
